// File: rtl/trap_ctrl.sv
// Trap sequencer: turns ecall/mret requests into CSR strobes, redirects fetch,
// then stalls and flushes the pipeline for FLUSH_CYCLES cycles.
module trap_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_x,
   input  logic             ecall_req,
   input  logic             mret_req,
   input  logic [31:0]      pc_in,
   input  logic [31:0]      mtvec_in,
   input  logic [31:0]      mepc_in,
   output logic             ecall,
   output logic             mret,
   output logic [31:0]      trap_pc,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] trap_count
);

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      EXIT,
      REDIRECT,
      FLUSH
   } state_t;

   // The FLUSH state counts down to zero, so it is loaded with one less than the hold length.
   localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

   state_t      state;
   logic [3:0]  flush_cnt;
   logic        kind;
   logic [31:0] redirect_base;

   // kind: 0 = ecall (redirect to mtvec base), 1 = mret (redirect to mepc).
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state      <= IDLE;
         flush_cnt  <= 4'd0;
         kind       <= 1'b0;
         trap_pc    <= 32'd0;
         trap_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ecall_req) begin
                  trap_pc <= pc_in;
                  kind    <= 1'b0;
                  state   <= ENTER;
               end else if (mret_req) begin
                  kind  <= 1'b1;
                  state <= EXIT;
               end
            end
            ENTER: begin
               if (trap_count != {CNT_W{1'b1}}) begin
                  trap_count <= trap_count + 1'b1;
               end
               state <= REDIRECT;
            end
            EXIT: begin
               state <= REDIRECT;
            end
            REDIRECT: begin
               if (FLUSH_CYCLES == 0) begin
                  state <= IDLE;
               end else begin
                  flush_cnt <= FLUSH_LOAD;
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               if (flush_cnt == 4'd0) begin
                  state <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes decode the registered state only, so they are stable when the CSR file samples at negedge.
   assign ecall          = (state == ENTER);
   assign mret           = (state == EXIT);
   assign redirect_valid = (state == REDIRECT);
   assign flush          = (state == FLUSH);
   assign stall          = (state != IDLE);

   // Synchronous traps always land on the mtvec base, even in vectored mode.
   assign redirect_base = kind ? mepc_in : mtvec_in;
   assign redirect_pc   = redirect_valid ? (redirect_base & 32'hFFFF_FFFC) : 32'd0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a timeline model of each trap checked every cycle,
// plus literal checks and two extra instances for FLUSH_CYCLES=0 and CNT_W=2.
module tb_trap_ctrl;

   localparam int F = 2;

   logic        clk;
   logic        reset_x;
   logic        ecall_req;
   logic        mret_req;
   logic [31:0] pc_in;
   logic [31:0] mtvec_in;
   logic [31:0] mepc_in;

   logic        ecall, mret, redirect_valid, stall, flush;
   logic [31:0] trap_pc, redirect_pc;
   logic [15:0] trap_count;

   logic        ecall0, mret0, redirect_valid0, stall0, flush0;
   logic [31:0] trap_pc0, redirect_pc0;
   logic [15:0] trap_count0;

   logic        ecall2, mret2, redirect_valid2, stall2, flush2;
   logic [31:0] trap_pc2, redirect_pc2;
   logic [1:0]  trap_count2;

   int vectors;
   int miscompares;
   bit checkEn;

   int rvCount, mretCount, flushCount, flush0Count;

   trap_ctrl #(.FLUSH_CYCLES(F), .CNT_W(16)) dut (
      .clk(clk), .reset_x(reset_x), .ecall_req(ecall_req), .mret_req(mret_req),
      .pc_in(pc_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
      .ecall(ecall), .mret(mret), .trap_pc(trap_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall(stall), .flush(flush), .trap_count(trap_count)
   );

   trap_ctrl #(.FLUSH_CYCLES(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset_x(reset_x), .ecall_req(ecall_req), .mret_req(mret_req),
      .pc_in(pc_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
      .ecall(ecall0), .mret(mret0), .trap_pc(trap_pc0), .redirect_valid(redirect_valid0),
      .redirect_pc(redirect_pc0), .stall(stall0), .flush(flush0), .trap_count(trap_count0)
   );

   trap_ctrl #(.FLUSH_CYCLES(F), .CNT_W(2)) dut2 (
      .clk(clk), .reset_x(reset_x), .ecall_req(ecall_req), .mret_req(mret_req),
      .pc_in(pc_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
      .ecall(ecall2), .mret(mret2), .trap_pc(trap_pc2), .redirect_valid(redirect_valid2),
      .redirect_pc(redirect_pc2), .stall(stall2), .flush(flush2), .trap_count(trap_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timeline model: an accepted request starts a sequence; m_off is the cycle number within it
   // (1 = strobe, 2 = redirect, 3..2+F = flush), and the block is free again after that.
   bit          m_busy;
   int          m_off;
   bit          m_isEcall;
   logic [31:0] m_trapPc;
   int          m_count;

   always @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         m_busy    <= 1'b0;
         m_off     <= 0;
         m_isEcall <= 1'b0;
         m_trapPc  <= 32'd0;
         m_count   <= 0;
      end else if (m_busy) begin
         if (m_off + 1 >= 3 + F) m_busy <= 1'b0;
         m_off <= m_off + 1;
         if (m_off == 1 && m_isEcall && m_count < 65535) m_count <= m_count + 1;
      end else if (ecall_req || mret_req) begin
         m_busy    <= 1'b1;
         m_off     <= 1;
         m_isEcall <= ecall_req;
         if (ecall_req) m_trapPc <= pc_in;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle compare of the main instance against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         logic        eEcall, eMret, eRv, eFlush;
         logic [31:0] eRpc;
         eEcall = m_busy && m_off == 1 && m_isEcall;
         eMret  = m_busy && m_off == 1 && !m_isEcall;
         eRv    = m_busy && m_off == 2;
         eFlush = m_busy && m_off >= 3 && m_off <= 2 + F;
         eRpc   = eRv ? ((m_isEcall ? mtvec_in : mepc_in) & 32'hFFFF_FFFC) : 32'd0;
         checkOutput("model_ecall", {31'd0, ecall}, {31'd0, eEcall});
         checkOutput("model_mret", {31'd0, mret}, {31'd0, eMret});
         checkOutput("model_redirect_valid", {31'd0, redirect_valid}, {31'd0, eRv});
         checkOutput("model_redirect_pc", redirect_pc, eRpc);
         checkOutput("model_flush", {31'd0, flush}, {31'd0, eFlush});
         checkOutput("model_stall", {31'd0, stall}, {31'd0, m_busy});
         checkOutput("model_trap_pc", trap_pc, m_trapPc);
         checkOutput("model_trap_count", {16'd0, trap_count}, m_count[31:0]);
      end
   end

   always @(negedge clk) begin
      rvCount     += int'(redirect_valid);
      mretCount   += int'(mret);
      flushCount  += int'(flush);
      flush0Count += int'(flush0);
   end

   task automatic applyStimulus(input logic e, input logic m, input logic [31:0] pc,
                                input logic [31:0] tv, input logic [31:0] ep);
      ecall_req = e;
      mret_req  = m;
      pc_in     = pc;
      mtvec_in  = tv;
      mepc_in   = ep;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      checkEn = 1'b0;
      rvCount = 0; mretCount = 0; flushCount = 0; flush0Count = 0;
      reset_x = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h40, 32'h100, 32'h0);
      #22;
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
      checkOutput("reset_trap_count", {16'd0, trap_count}, 32'd0);
      reset_x = 1'b1;
      checkEn = 1'b1;
      step(2);

      // Test 1: basic ecall with the default two flush cycles.
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h100, 32'h0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h40, 32'h100, 32'h0);
      @(negedge clk);
      checkOutput("t1_ecall", {31'd0, ecall}, 32'd1);
      checkOutput("t1_trap_pc", trap_pc, 32'h40);
      @(negedge clk);
      checkOutput("t1_ecall_off", {31'd0, ecall}, 32'd0);
      checkOutput("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      checkOutput("t1_redirect_pc", redirect_pc, 32'h100);
      checkOutput("t1_trap_count", {16'd0, trap_count}, 32'd1);
      checkOutput("t1_f0_redirect_pc", redirect_pc0, 32'h100);
      @(negedge clk);
      checkOutput("t1_flush_a", {31'd0, flush}, 32'd1);
      checkOutput("t1_f0_idle", {31'd0, stall0}, 32'd0);
      @(negedge clk);
      checkOutput("t1_flush_b", {31'd0, flush}, 32'd1);
      @(negedge clk);
      checkOutput("t1_stall_done", {31'd0, stall}, 32'd0);
      checkOutput("t1_flush_done", {31'd0, flush}, 32'd0);
      step(1);

      // Test 2: vectored mtvec still lands on the base; then an mret to a misaligned mepc.
      applyStimulus(1'b1, 1'b0, 32'h80, 32'h201, 32'h0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h80, 32'h201, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("t2_vectored_pc", redirect_pc, 32'h200);
      step(4);
      applyStimulus(1'b0, 1'b1, 32'h80, 32'h201, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h80, 32'h201, 32'h47);
      @(negedge clk);
      checkOutput("t2_mret", {31'd0, mret}, 32'd1);
      checkOutput("t2_no_ecall", {31'd0, ecall}, 32'd0);
      @(negedge clk);
      checkOutput("t2_mret_off", {31'd0, mret}, 32'd0);
      checkOutput("t2_mepc_pc", redirect_pc, 32'h44);
      checkOutput("t2_count_held", {16'd0, trap_count}, 32'd2);
      step(4);

      // Test 3: simultaneous requests take the ecall path.
      applyStimulus(1'b1, 1'b1, 32'h300, 32'h100, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h300, 32'h100, 32'h47);
      @(negedge clk);
      checkOutput("t3_ecall", {31'd0, ecall}, 32'd1);
      checkOutput("t3_no_mret", {31'd0, mret}, 32'd0);
      checkOutput("t3_trap_pc", trap_pc, 32'h300);
      @(negedge clk);
      checkOutput("t3_redirect_pc", redirect_pc, 32'h100);
      step(4);

      // Test 4: mret pulses during ENTER and FLUSH are dropped.
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h100, 32'h47);
      rvCount = 0; mretCount = 0; flushCount = 0;
      step(1);
      applyStimulus(1'b0, 1'b1, 32'h400, 32'h100, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h400, 32'h100, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b1, 32'h400, 32'h100, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h400, 32'h100, 32'h47);
      step(2);
      checkOutput("t4_redirects", rvCount, 32'd1);
      checkOutput("t4_mret_strobes", mretCount, 32'd0);
      checkOutput("t4_flush_cycles", flushCount, 32'd2);
      checkOutput("t4_idle", {31'd0, stall}, 32'd0);
      step(2);

      // Test 5: asynchronous reset in the middle of FLUSH.
      applyStimulus(1'b1, 1'b0, 32'h500, 32'h100, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h500, 32'h100, 32'h47);
      step(2);
      checkOutput("t5_in_flush", {31'd0, flush}, 32'd1);
      #1 reset_x = 1'b0;
      #1;
      checkOutput("t5_flush_cleared", {31'd0, flush}, 32'd0);
      checkOutput("t5_stall_cleared", {31'd0, stall}, 32'd0);
      checkOutput("t5_rv_cleared", {31'd0, redirect_valid}, 32'd0);
      checkOutput("t5_count_cleared", {16'd0, trap_count}, 32'd0);
      checkOutput("t5_f0_count_cleared", {16'd0, trap_count0}, 32'd0);
      #10 reset_x = 1'b1;
      step(2);

      // Test 6: narrow counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h600 + 32'(i * 4), 32'h100, 32'h47);
         step(1);
         applyStimulus(1'b0, 1'b0, 32'h600, 32'h100, 32'h47);
         step(6);
      end
      checkOutput("t6_sat_count", {30'd0, trap_count2}, 32'd3);
      checkOutput("t6_wide_count", {16'd0, trap_count}, 32'd5);
      applyStimulus(1'b1, 1'b0, 32'h700, 32'h100, 32'h47);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h700, 32'h100, 32'h47);
      step(6);
      checkOutput("t6_sat_held", {30'd0, trap_count2}, 32'd3);
      checkOutput("f0_never_flushed", flush0Count, 32'd0);

      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
